// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction fetch stage.
//   PC_W / IR_W          : instruction address / word widths
//   DEF_BUF_DEPTH        : default prefetch FIFO depth
//   DEF_RESET_PC         : default PC after reset
//   fetch_state_e        : fetch FSM states (RUN fetching, WAIT squashed)
//   fetch_entry_t        : prefetch FIFO payload {pc, ir}
package fetch_pkg;

    localparam int unsigned PC_W          = 11;
    localparam int unsigned IR_W          = 32;
    localparam int unsigned DEF_BUF_DEPTH = 2;
    localparam logic [PC_W-1:0] DEF_RESET_PC = '0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [IR_W-1:0] ir;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small synchronous prefetch FIFO (shift-register organisation).
// Entry 0 is always the head, so the head and its valid flag come straight
// from registers.
//   clk, rst_n   : clock, async active-low reset
//   push_i       : write push_data_i behind the current (post-pop) contents
//   push_data_i  : entry to write
//   pop_i        : retire the head
//   flush_i      : drop every entry (wins over push/pop)
//   head_o       : head entry (registered)
//   valid_o      : head holds a live entry (registered)
//   count_o      : number of live entries (registered)
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_BUF_DEPTH,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  fetch_entry_t       push_data_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output fetch_entry_t       head_o,
    output logic               valid_o,
    output logic [CNT_W-1:0]   count_o
);

    fetch_entry_t     entries_q [DEPTH];
    fetch_entry_t     entries_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] base_c;

    // Next contents: optional shift-down on pop, then write at the first free slot.
    always_comb begin
        entries_d = entries_q;
        count_d   = count_q;
        base_c    = count_q;
        if (flush_i) begin
            count_d = '0;
        end else begin
            if (pop_i && (count_q != '0)) begin
                for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                    entries_d[i] = entries_q[i+1];
                end
                base_c = count_q - CNT_W'(1);
            end
            count_d = base_c;
            if (push_i && (base_c != CNT_W'(DEPTH))) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    if (base_c == CNT_W'(i)) begin
                        entries_d[i] = push_data_i;
                    end
                end
                count_d = base_c + CNT_W'(1);
            end
        end
    end

    // Storage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            count_q   <= count_d;
            entries_q <= entries_d;
        end
    end

    // The issue rule upstream must make a push into a full buffer impossible.
    always @(posedge clk) begin
        if (rst_n && push_i && !flush_i) begin
            assert (base_c != CNT_W'(DEPTH))
            else $error("fetch_buffer: push into full FIFO");
        end
    end

    assign head_o  = entries_q[0];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the decoder over IR/PC/VALID,
// back-pressured by STALL and squashed by HALT / REDIRECT.
// Optional build macro FETCH_PERF_EN adds STALL_CYC and FETCH_CNT counters.
//   CLK, N_RST          : clock, async active-low reset
//   IMEM_RD, IMEM_ADDR  : fetch request / address (1-cycle read latency)
//   IMEM_DATA           : read data, valid the cycle after IMEM_RD
//   IR, PC, VALID       : FIFO head presented to the decoder
//   STALL, HALT         : decoder hold / control-flow flush
//   REDIRECT, REDIRECT_PC : new fetch target from execute
//   STALL_CYC, FETCH_CNT  : (FETCH_PERF_EN) saturating stall-cycle / pop counts
// IMEM_RD is combinational: it must see this cycle's HALT/REDIRECT.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned     BUF_DEPTH = DEF_BUF_DEPTH,
    parameter logic [PC_W-1:0] RESET_PC  = DEF_RESET_PC
) (
    input  logic            CLK,
    input  logic            N_RST,
    output logic            IMEM_RD,
    output logic [PC_W-1:0] IMEM_ADDR,
    input  logic [IR_W-1:0] IMEM_DATA,
    output logic [IR_W-1:0] IR,
    output logic [PC_W-1:0] PC,
    output logic            VALID,
`ifdef FETCH_PERF_EN
    output logic [15:0]     STALL_CYC,
    output logic [15:0]     FETCH_CNT,
`endif
    input  logic            STALL,
    input  logic            HALT,
    input  logic            REDIRECT,
    input  logic [PC_W-1:0] REDIRECT_PC
);

    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OCC_W = CNT_W + 1;

    fetch_state_e     state_q, state_d;
    logic [PC_W-1:0]  fpc_q, fpc_d;
    logic [PC_W-1:0]  ret_pc_q, ret_pc_d;
    logic             inflight_q, inflight_d;
    logic             kill_q, kill_d;

    fetch_entry_t     head_c;
    fetch_entry_t     push_data_c;
    logic             head_valid_c;
    logic [CNT_W-1:0] count_c;
    logic             pop_c;
    logic             halt_acc_c;
    logic             flush_c;
    logic             push_c;
    logic             issue_c;
    logic [OCC_W-1:0] occ_c;

    // Handshake decode, issue rule and return path.
    always_comb begin
        pop_c       = head_valid_c & ~STALL;
        halt_acc_c  = pop_c & HALT;
        flush_c     = halt_acc_c | REDIRECT;
        // Occupancy after this cycle: buffered + in flight - retired.
        occ_c       = {1'b0, count_c} + OCC_W'(inflight_q) - OCC_W'(pop_c);
        issue_c     = (state_q == ST_RUN) & ~HALT & ~REDIRECT
                      & (occ_c < OCC_W'(BUF_DEPTH));
        // A return arriving on a flush cycle is younger than the flush point.
        push_c      = inflight_q & ~kill_q & ~flush_c;
        push_data_c = '{pc: ret_pc_q, ir: IMEM_DATA};
    end

    // Next-state: FSM, fetch PC, in-flight / kill tracking.
    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        ret_pc_d   = ret_pc_q;
        inflight_d = issue_c;
        kill_d     = kill_q;

        if (issue_c) begin
            fpc_d    = fpc_q + PC_W'(1);
            ret_pc_d = fpc_q;
            kill_d   = 1'b0;
        end

        if (REDIRECT) begin
            state_d = ST_RUN;
            fpc_d   = REDIRECT_PC;
            kill_d  = 1'b1;
        end else if (halt_acc_c) begin
            state_d = ST_WAIT;
            kill_d  = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            state_q    <= ST_RUN;
            fpc_q      <= RESET_PC;
            ret_pc_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            ret_pc_q   <= ret_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buffer (
        .clk         (CLK),
        .rst_n       (N_RST),
        .push_i      (push_c),
        .push_data_i (push_data_c),
        .pop_i       (pop_c),
        .flush_i     (flush_c),
        .head_o      (head_c),
        .valid_o     (head_valid_c),
        .count_o     (count_c)
    );

    // Reset gating keeps the request low while N_RST is held.
    assign IMEM_RD   = issue_c & N_RST;
    assign IMEM_ADDR = fpc_q;
    assign IR        = head_c.ir;
    assign PC        = head_c.pc;
    assign VALID     = head_valid_c;

`ifdef FETCH_PERF_EN
    logic [15:0] stall_cyc_q, stall_cyc_d;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;

    // Saturating performance counters.
    always_comb begin
        stall_cyc_d = stall_cyc_q;
        fetch_cnt_d = fetch_cnt_q;
        if (head_valid_c && STALL && (stall_cyc_q != 16'hFFFF)) begin
            stall_cyc_d = stall_cyc_q + 16'd1;
        end
        if (pop_c && (fetch_cnt_q != 16'hFFFF)) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK or negedge N_RST) begin
        if (!N_RST) begin
            stall_cyc_q <= '0;
            fetch_cnt_q <= '0;
        end else begin
            stall_cyc_q <= stall_cyc_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign STALL_CYC = stall_cyc_q;
    assign FETCH_CNT = fetch_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage; the producer end of the decoder's IR/PC/VALID ↔ STALL/HALT interface. Fetches 32-bit words from instruction memory with fixed 1-cycle read latency and buffers them in a small prefetch FIFO. Presents the FIFO head to the decoder, holding it under STALL. On HALT it squashes everything and waits for a REDIRECT from the execute stage.

Parameters:
PC_W, 11, instruction address width (word addressed)
IR_W, 32, instruction word width
BUF_DEPTH, 2, prefetch FIFO entries (≥2 required for full throughput)
RESET_PC, 0, PC loaded at reset

Ports:
CLK  in  1  clock, rising edge
N_RST  in  1  asynchronous reset, active low
IMEM_RD  out  1  fetch request this cycle
IMEM_ADDR  out  PC_W  fetch address
IMEM_DATA  in  IR_W  read data, valid the cycle after IMEM_RD
IR  out  IR_W  instruction at FIFO head
PC  out  PC_W  address of IR
VALID  out  1  IR/PC hold a live instruction
STALL  in  1  decoder cannot accept; hold head
HALT  in  1  decoder consumed a control-flow/stop instruction; flush younger
REDIRECT  in  1  new fetch target from execute stage
REDIRECT_PC  in  PC_W  target address

Behaviour:
- Reset (async, N_RST=0): FPC<=RESET_PC; FIFO empty; inflight=0; kill=0; state RUN. IMEM_RD=0, VALID=0, IR=0, PC=0.
- State machine: RUN (fetching) and WAIT (squashed, no fetch).
- RUN→WAIT: VALID & ~STALL & HALT & ~REDIRECT. WAIT→RUN: REDIRECT. WAIT with no REDIRECT holds indefinitely; the decoder's stop case relies on this.
- Pop: pop = VALID & ~STALL. Head leaves FIFO; next entry (if any) appears the following cycle.
- Issue: IMEM_RD = (state==RUN) & ~HALT & ~REDIRECT & (count + inflight − pop < BUF_DEPTH).
  - IMEM_ADDR = FPC.
  - On issue, FPC <= FPC+1 (wraps mod 2^PC_W) and inflight<=1 for the next cycle.
- Return: the cycle after an issue, {IMEM_DATA, issued addr} is pushed unless kill is set. A push into an empty FIFO gives VALID=1 the next cycle; fetch-to-VALID latency is 2 cycles.
- HALT (accepted, i.e. VALID & ~STALL):
  - Flush all FIFO entries behind the head.
  - Set kill so an in-flight return is discarded.
  - No issue that cycle.
- HALT with STALL=1 is ignored. The decoder never asserts HALT with STALL.
- REDIRECT (any state, highest priority):
  - Flush FIFO.
  - Kill in-flight return.
  - FPC<=REDIRECT_PC; state RUN; no issue that cycle.
  - VALID=0 for 2 cycles, then first fetch issues at REDIRECT_PC.
- Simultaneous HALT and REDIRECT: REDIRECT wins; state stays/becomes RUN.
- FIFO full with inflight: guaranteed not to overflow by the issue rule. Push on a full FIFO is an assertion failure.
- Steady state, no stalls: one instruction per cycle, PC incrementing by 1.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs STALL_CYC (16 bit) and FETCH_CNT (16 bit), both saturating at 0xFFFF and cleared by reset.
  - STALL_CYC counts cycles with VALID & STALL.
  - FETCH_CNT counts pops.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package fetch_pkg holds:
  - PC_W, IR_W, RESET_PC defaults
  - fetch state enum {RUN, WAIT}
  - FIFO entry struct {pc, ir}
- One sub-module, fetch_buffer: synchronous FIFO with push/pop/flush and count output, head exposed as registers. fetch_unit contains the FSM, FPC, inflight/kill tracking and the issue rule.

Test Plan:
- Reset release, IMEM returns word = 0x1000_0000+addr, STALL=0 → IMEM_ADDR 0,1,2,…; VALID high from cycle 2; PC 0,1,2,… every cycle; IR matches.
- STALL held 3 cycles at PC=5 → IR/PC stay at 5; no more than BUF_DEPTH entries plus in-flight; no overflow. After release, PC 6,7,… with no gap or duplicate.
- HALT at PC=7, then REDIRECT_PC=0x40 three cycles later → entries 8,9 dropped; VALID=0 through the wait; IMEM_RD=0 in WAIT; next VALID shows PC=0x40.
- REDIRECT_PC=0x7FF with no HALT while streaming → flushed; PC 0x7FF then 0x000 (wrap).
- HALT and REDIRECT same cycle, REDIRECT_PC=0x10 → no WAIT entry; next instruction PC=0x10.
- N_RST asserted mid-stream with STALL=1 and FIFO full → all outputs 0 immediately; after release fetch restarts at RESET_PC. With FETCH_PERF_EN, counters read 0.
